pool2d_ahb_engine: RTL and testbench

- Parametrised 2-D pooling engine; AHB-Lite single-transfer master.
- Reads an unsigned 8-bit feature map (row-major, one byte per pixel) from SRC_BASE, applies KxK max or average pooling at a configurable stride, and writes one byte per output pixel to DST_BASE.
- Sits between the convolution stage and the next layer; started by the layer sequencer, reports finish/error back to it.

---
 rtl/pool2d_ahb_engine_if.sv | 26 ++
 rtl/pool2d_ahb_engine.sv | 204 ++++++++++++++++++++
 tb/tb_pool2d_ahb_engine.sv | 307 ++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/pool2d_ahb_engine_if.sv
// AHB-Lite single-transfer bus bundle between the pooling engine (master)
// and the memory-side slave.
interface pool2d_ahb_engine_if;
  logic [31:0] haddr;
  logic [1:0]  htrans;
  logic        hwrite;
  logic [2:0]  hsize;
  logic [2:0]  hburst;
  logic [3:0]  hprot;
  logic [31:0] hwdata;
  logic        hready_in;
  logic        sel;
  logic [31:0] hrdata;
  logic        hready_out;
  logic        hresp;

  modport master (
    output haddr, htrans, hwrite, hsize, hburst, hprot, hwdata, hready_in, sel,
    input  hrdata, hready_out, hresp
  );

  modport slave (
    input  haddr, htrans, hwrite, hsize, hburst, hprot, hwdata, hready_in, sel,
    output hrdata, hready_out, hresp
  );
endinterface

// File: rtl/pool2d_ahb_engine.sv
// KxK max/average pooling engine over an 8-bit row-major feature map.
// Reads every window pixel with a single AHB-Lite byte transfer and
// writes one result byte per output pixel.
//
// state   | meaning
// --------+--------------------------------------------------
// IDLE    | waiting for start
// RD_ADDR | issue read address phase once the bus is ready
// RD_DATA | read data phase, capture addressed byte lane
// ACC     | fold captured byte into max / sum accumulator
// WR_ADDR | issue write address phase for the window result
// WR_DATA | write data phase, result held on hwdata
// NEXT    | step to the next output pixel or finish
// DONE    | run complete, start re-launches
// ERR     | slave returned ERROR, held until reset
module pool2d_ahb_engine #(
  parameter int          FMAP_W   = 82,
  parameter int          FMAP_H   = 82,
  parameter int          POOL_K   = 2,
  parameter int          STRIDE   = 2,
  parameter logic [31:0] SRC_BASE = 32'h4002_0000,
  parameter logic [31:0] DST_BASE = 32'h4003_0000
) (
  input  logic clk,
  input  logic reset,
  input  logic start,
  input  logic mode,
  output logic finish,
  output logic busy,
  output logic error,
  pool2d_ahb_engine_if.master ahb_interface_0
);

  localparam int OUT_W = (FMAP_W - POOL_K) / STRIDE + 1;
  localparam int OUT_H = (FMAP_H - POOL_K) / STRIDE + 1;
  // Average divides by K*K, which is 4 or 16, so a shift is exact.
  localparam int SHIFT = (POOL_K == 4) ? 4 : 2;

  localparam logic [10:0] OCOL_LAST = 11'(OUT_W - 1);
  localparam logic [10:0] OROW_LAST = 11'(OUT_H - 1);
  localparam logic [1:0]  WIN_LAST  = 2'(POOL_K - 1);
  localparam logic [31:0] FW        = 32'(FMAP_W);
  localparam logic [31:0] ST        = 32'(STRIDE);
  localparam logic [31:0] OW        = 32'(OUT_W);

  localparam logic [3:0] IDLE    = 4'd0;
  localparam logic [3:0] RD_ADDR = 4'd1;
  localparam logic [3:0] RD_DATA = 4'd2;
  localparam logic [3:0] ACC     = 4'd3;
  localparam logic [3:0] WR_ADDR = 4'd4;
  localparam logic [3:0] WR_DATA = 4'd5;
  localparam logic [3:0] NEXT    = 4'd6;
  localparam logic [3:0] DONE    = 4'd7;
  localparam logic [3:0] ERR     = 4'd8;

  logic [3:0]  state;
  logic [10:0] orow, ocol;
  logic [1:0]  wr, wc;
  logic [11:0] acc;
  logic [7:0]  rd_byte;
  logic        mode_q;

  logic [31:0] rd_addr, wr_addr;
  logic [7:0]  result;
  logic        first_px, win_done;

  assign rd_addr  = SRC_BASE + (32'(orow) * ST + 32'(wr)) * FW + 32'(ocol) * ST + 32'(wc);
  assign wr_addr  = DST_BASE + 32'(orow) * OW + 32'(ocol);
  assign result   = mode_q ? acc[SHIFT +: 8] : acc[7:0];
  assign first_px = (wr == 2'd0) && (wc == 2'd0);
  assign win_done = (wr == WIN_LAST) && (wc == WIN_LAST);

  assign finish = (state == DONE);
  assign error  = (state == ERR);
  assign busy   = !((state == IDLE) || (state == DONE) || (state == ERR));

  // Sequencer: window scan, accumulation and output-pixel stepping.
  always_ff @(posedge clk) begin
    if (reset) begin
      state   <= IDLE;
      orow    <= '0;
      ocol    <= '0;
      wr      <= '0;
      wc      <= '0;
      acc     <= '0;
      rd_byte <= '0;
      mode_q  <= 1'b0;
    end else begin
      unique case (state)
        IDLE, DONE: begin
          if (start) begin
            mode_q <= mode;
            orow   <= '0;
            ocol   <= '0;
            wr     <= '0;
            wc     <= '0;
            acc    <= '0;
            state  <= RD_ADDR;
          end
        end
        RD_ADDR: if (ahb_interface_0.hready_out) state <= RD_DATA;
        RD_DATA: begin
          if (ahb_interface_0.hready_out) begin
            if (ahb_interface_0.hresp) begin
              state <= ERR;
            end else begin
              rd_byte <= ahb_interface_0.hrdata[{rd_addr[1:0], 3'b000} +: 8];
              state   <= ACC;
            end
          end
        end
        ACC: begin
          if (first_px)                acc <= {4'd0, rd_byte};
          else if (mode_q)             acc <= acc + {4'd0, rd_byte};
          else if (rd_byte > acc[7:0]) acc <= {4'd0, rd_byte};
          if (win_done) begin
            state <= WR_ADDR;
          end else begin
            state <= RD_ADDR;
            if (wc == WIN_LAST) begin
              wc <= 2'd0;
              wr <= wr + 2'd1;
            end else begin
              wc <= wc + 2'd1;
            end
          end
        end
        WR_ADDR: if (ahb_interface_0.hready_out) state <= WR_DATA;
        WR_DATA: begin
          if (ahb_interface_0.hready_out)
            state <= ahb_interface_0.hresp ? ERR : NEXT;
        end
        NEXT: begin
          wr <= 2'd0;
          wc <= 2'd0;
          if (ocol == OCOL_LAST) begin
            ocol <= '0;
            if (orow == OROW_LAST) begin
              state <= DONE;
            end else begin
              orow  <= orow + 11'd1;
              state <= RD_ADDR;
            end
          end else begin
            ocol  <= ocol + 11'd1;
            state <= RD_ADDR;
          end
        end
        ERR:     state <= ERR;
        default: state <= IDLE;
      endcase
    end
  end

  // Bus drive: address phase is gated by hready_out; address, hprot and
  // write data stay put through the data phase so waits see a stable bus.
  always_comb begin
    ahb_interface_0.haddr     = '0;
    ahb_interface_0.htrans    = 2'b00;
    ahb_interface_0.hwrite    = 1'b0;
    ahb_interface_0.hsize     = 3'b000;
    ahb_interface_0.hburst    = 3'b000;
    ahb_interface_0.hprot     = 4'b0000;
    ahb_interface_0.hwdata    = '0;
    ahb_interface_0.hready_in = 1'b0;
    ahb_interface_0.sel       = 1'b0;
    case (state)
      RD_ADDR: begin
        ahb_interface_0.haddr = rd_addr;
        ahb_interface_0.hprot = 4'b0001;
        if (ahb_interface_0.hready_out) begin
          ahb_interface_0.htrans    = 2'b10;
          ahb_interface_0.hready_in = 1'b1;
          ahb_interface_0.sel       = 1'b1;
        end
      end
      RD_DATA: begin
        ahb_interface_0.haddr = rd_addr;
        ahb_interface_0.hprot = 4'b0001;
        ahb_interface_0.sel   = 1'b1;
      end
      WR_ADDR: begin
        ahb_interface_0.haddr  = wr_addr;
        ahb_interface_0.hprot  = 4'b1001;
        ahb_interface_0.hwdata = {4{result}};
        if (ahb_interface_0.hready_out) begin
          ahb_interface_0.htrans    = 2'b10;
          ahb_interface_0.hready_in = 1'b1;
          ahb_interface_0.sel       = 1'b1;
          ahb_interface_0.hwrite    = 1'b1;
        end
      end
      WR_DATA: begin
        ahb_interface_0.haddr  = wr_addr;
        ahb_interface_0.hprot  = 4'b1001;
        ahb_interface_0.hwdata = {4{result}};
        ahb_interface_0.sel    = 1'b1;
        ahb_interface_0.hwrite = 1'b1;
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_pool2d_ahb_engine.sv
// Bench for pool2d_ahb_engine: three engine geometries share one AHB slave
// model; results are compared with a plain-arithmetic pooling model.
module tb_pool2d_ahb_engine;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic reset, start_r, mode;
  int   cur;
  int   n_tests = 0;
  int   n_fail  = 0;

  int          cfg_w[3]   = '{4, 5, 10};
  int          cfg_h[3]   = '{4, 5, 9};
  int          cfg_k[3]   = '{2, 2, 4};
  int          cfg_s[3]   = '{2, 1, 3};
  logic [31:0] cfg_src[3] = '{32'h4002_0000, 32'h4002_0000, 32'h0000_1001};
  logic [31:0] cfg_dst[3] = '{32'h4003_0000, 32'h4003_0000, 32'h0000_8003};

  pool2d_ahb_engine_if a0 ();
  pool2d_ahb_engine_if a1 ();
  pool2d_ahb_engine_if a2 ();

  logic [31:0] s_hrdata;
  logic        s_hready, s_hresp;
  assign a0.hrdata = s_hrdata;  assign a0.hready_out = s_hready;  assign a0.hresp = s_hresp;
  assign a1.hrdata = s_hrdata;  assign a1.hready_out = s_hready;  assign a1.hresp = s_hresp;
  assign a2.hrdata = s_hrdata;  assign a2.hready_out = s_hready;  assign a2.hresp = s_hresp;

  logic st0, st1, st2, fin0, fin1, fin2, bsy0, bsy1, bsy2, err0, err1, err2;
  assign st0 = start_r && (cur == 0);
  assign st1 = start_r && (cur == 1);
  assign st2 = start_r && (cur == 2);

  pool2d_ahb_engine #(.FMAP_W(4), .FMAP_H(4), .POOL_K(2), .STRIDE(2)) u_dut0 (
    .clk(clk), .reset(reset), .start(st0), .mode(mode),
    .finish(fin0), .busy(bsy0), .error(err0), .ahb_interface_0(a0));
  pool2d_ahb_engine #(.FMAP_W(5), .FMAP_H(5), .POOL_K(2), .STRIDE(1)) u_dut1 (
    .clk(clk), .reset(reset), .start(st1), .mode(mode),
    .finish(fin1), .busy(bsy1), .error(err1), .ahb_interface_0(a1));
  pool2d_ahb_engine #(.FMAP_W(10), .FMAP_H(9), .POOL_K(4), .STRIDE(3),
                      .SRC_BASE(32'h0000_1001), .DST_BASE(32'h0000_8003)) u_dut2 (
    .clk(clk), .reset(reset), .start(st2), .mode(mode),
    .finish(fin2), .busy(bsy2), .error(err2), .ahb_interface_0(a2));

  logic [31:0] m_haddr, m_hwdata;
  logic [1:0]  m_htrans;
  logic [2:0]  m_hsize, m_hburst;
  logic [3:0]  m_hprot;
  logic        m_hwrite, m_hready_in, m_sel, m_finish, m_busy, m_error;
  assign m_haddr     = (cur == 0) ? a0.haddr     : (cur == 1) ? a1.haddr     : a2.haddr;
  assign m_hwdata    = (cur == 0) ? a0.hwdata    : (cur == 1) ? a1.hwdata    : a2.hwdata;
  assign m_htrans    = (cur == 0) ? a0.htrans    : (cur == 1) ? a1.htrans    : a2.htrans;
  assign m_hsize     = (cur == 0) ? a0.hsize     : (cur == 1) ? a1.hsize     : a2.hsize;
  assign m_hburst    = (cur == 0) ? a0.hburst    : (cur == 1) ? a1.hburst    : a2.hburst;
  assign m_hprot     = (cur == 0) ? a0.hprot     : (cur == 1) ? a1.hprot     : a2.hprot;
  assign m_hwrite    = (cur == 0) ? a0.hwrite    : (cur == 1) ? a1.hwrite    : a2.hwrite;
  assign m_hready_in = (cur == 0) ? a0.hready_in : (cur == 1) ? a1.hready_in : a2.hready_in;
  assign m_sel       = (cur == 0) ? a0.sel       : (cur == 1) ? a1.sel       : a2.sel;
  assign m_finish    = (cur == 0) ? fin0 : (cur == 1) ? fin1 : fin2;
  assign m_busy      = (cur == 0) ? bsy0 : (cur == 1) ? bsy1 : bsy2;
  assign m_error     = (cur == 0) ? err0 : (cur == 1) ? err1 : err2;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  // Slave model state
  logic [7:0]  mem [logic [31:0]];
  logic [31:0] obs_addr[$], obs_data[$];
  int          rd_waits, wr_waits, err_read, n_reads, n_xfers, wait_left, sl_kk;
  bit          stall_addr, dphase, dp_write, dp_first, exp_wr;
  logic [31:0] dp_addr, dp_wdata, rd_word;
  logic [7:0]  rd_val;

  // Slave decisions are made on the falling edge; address phases are
  // sampled 1 time unit later once htrans has reacted to hready_out.
  always @(negedge clk) begin
    if (reset) begin
      dphase   = 1'b0;
      s_hready = 1'b1;
      s_hresp  = 1'b0;
    end else if (dphase) begin
      check_val("dp_haddr", m_haddr, dp_addr);
      check_val("dp_sel", 32'(m_sel), 32'd1);
      check_val("dp_htrans", 32'(m_htrans), 32'd0);
      if (dp_write) begin
        if (dp_first) dp_wdata = m_hwdata;
        else check_val("dp_hwdata", m_hwdata, dp_wdata);
      end
      dp_first = 1'b0;
      if (wait_left > 0) begin
        s_hready = 1'b0;
        s_hresp  = 1'b0;
        wait_left--;
      end else begin
        s_hready = 1'b1;
        dphase   = 1'b0;
        if (dp_write) begin
          s_hresp = 1'b0;
          obs_addr.push_back(dp_addr);
          obs_data.push_back(m_hwdata);
        end else begin
          n_reads++;
          s_hresp = (n_reads == err_read);
          rd_val  = mem.exists(dp_addr) ? mem[dp_addr] : 8'h00;
          rd_word = $urandom;
          rd_word[{dp_addr[1:0], 3'b000} +: 8] = rd_val;
          s_hrdata = rd_word;
        end
      end
    end else begin
      s_hresp  = 1'b0;
      s_hready = stall_addr ? ($urandom_range(0, 3) != 0) : 1'b1;
      #1;
      if (s_hready && m_htrans == 2'b10) begin
        sl_kk  = cfg_k[cur] * cfg_k[cur];
        exp_wr = ((n_xfers % (sl_kk + 1)) == sl_kk);
        check_val("ap_hwrite", 32'(m_hwrite), 32'(exp_wr));
        check_val("ap_hprot", 32'(m_hprot), exp_wr ? 32'd9 : 32'd1);
        check_val("ap_hsize", 32'(m_hsize), 32'd0);
        check_val("ap_hburst", 32'(m_hburst), 32'd0);
        check_val("ap_hready_in", 32'(m_hready_in), 32'd1);
        check_val("ap_sel", 32'(m_sel), 32'd1);
        n_xfers++;
        dphase    = 1'b1;
        dp_first  = 1'b1;
        dp_addr   = m_haddr;
        dp_write  = m_hwrite;
        wait_left = m_hwrite ? wr_waits : rd_waits;
      end
    end
  end

  task automatic check_all_zero(input string tag);
    check_val({tag, "_finish"}, 32'(m_finish), 32'd0);
    check_val({tag, "_busy"}, 32'(m_busy), 32'd0);
    check_val({tag, "_error"}, 32'(m_error), 32'd0);
    check_val({tag, "_htrans"}, 32'(m_htrans), 32'd0);
    check_val({tag, "_haddr"}, m_haddr, 32'd0);
    check_val({tag, "_sel"}, 32'(m_sel), 32'd0);
    check_val({tag, "_hwrite"}, 32'(m_hwrite), 32'd0);
    check_val({tag, "_hprot"}, 32'(m_hprot), 32'd0);
    check_val({tag, "_hwdata"}, m_hwdata, 32'd0);
    check_val({tag, "_hready_in"}, 32'(m_hready_in), 32'd0);
  endtask

  // kind: 0 = pixel index, 1 = all 0xFF with pixel 12 cleared, 2 = random.
  // cut > 0: assert reset while the write after 'cut' completed writes is
  // in its data phase, check the outputs and return without a result check.
  task automatic run_job(input int d, input bit md, input int rw, input int ww,
                         input bit stall, input int errn, input bit poke,
                         input int kind, input int cut);
    int w, h, k, s, ow, oh, best, sum, p, nexp;
    int img[];
    logic [31:0] src, dst;
    logic [31:0] exp_addr[$], exp_data[$];
    bit done;
    cur = d;
    w = cfg_w[d]; h = cfg_h[d]; k = cfg_k[d]; s = cfg_s[d];
    src = cfg_src[d]; dst = cfg_dst[d];
    ow = (w - k) / s + 1;
    oh = (h - k) / s + 1;
    img = new[w * h];
    mem.delete();
    for (int i = 0; i < w * h; i++) begin
      if (kind == 0)      img[i] = i % 256;
      else if (kind == 1) img[i] = (i == 12) ? 0 : 255;
      else                img[i] = int'($urandom_range(0, 255));
      mem[src + 32'(i)] = 8'(img[i]);
    end
    for (int oy = 0; oy < oh; oy++) begin
      for (int ox = 0; ox < ow; ox++) begin
        best = 0;
        sum  = 0;
        for (int ky = 0; ky < k; ky++) begin
          for (int kx = 0; kx < k; kx++) begin
            p = img[(oy * s + ky) * w + ox * s + kx];
            sum += p;
            if (p > best) best = p;
          end
        end
        exp_addr.push_back(dst + 32'(oy * ow + ox));
        exp_data.push_back({4{8'(md ? sum / (k * k) : best)}});
      end
    end
    obs_addr.delete();
    obs_data.delete();
    n_reads = 0; n_xfers = 0;
    rd_waits = rw; wr_waits = ww; stall_addr = stall; err_read = errn;
    @(negedge clk); #4;
    mode = md;
    start_r = 1'b1;
    @(negedge clk); #4;
    start_r = 1'b0;
    check_val("start_busy", 32'(m_busy), 32'd1);
    check_val("start_finish", 32'(m_finish), 32'd0);
    if (poke) begin
      repeat (4) @(negedge clk);
      #4;
      mode = ~md;
      start_r = 1'b1;
      @(negedge clk); #4;
      start_r = 1'b0;
    end
    if (cut > 0) begin
      done = 1'b0;
      for (int c = 0; c < 5000 && !done; c++) begin
        @(negedge clk); #4;
        done = (obs_addr.size() >= cut) && m_sel && m_hwrite && (m_htrans == 2'b00);
      end
      check_val("reach_wr_data", 32'(done), 32'd1);
      reset = 1'b1;
      @(posedge clk); #1;
      check_all_zero("mid_reset");
      @(negedge clk); #4;
      reset = 1'b0;
      return;
    end
    done = 1'b0;
    for (int c = 0; c < 20000 && !done; c++) begin
      @(negedge clk); #4;
      done = m_finish || m_error;
    end
    check_val("job_done", 32'(done), 32'd1);
    if (errn == 0) begin
      check_val("finish", 32'(m_finish), 32'd1);
      check_val("error", 32'(m_error), 32'd0);
      check_val("busy_done", 32'(m_busy), 32'd0);
      check_val("n_reads", 32'(n_reads), 32'(ow * oh * k * k));
      check_val("n_writes", 32'(obs_addr.size()), 32'(exp_addr.size()));
      nexp = (obs_addr.size() < exp_addr.size()) ? obs_addr.size() : exp_addr.size();
      for (int i = 0; i < nexp; i++) begin
        check_val("wr_addr", obs_addr[i], exp_addr[i]);
        check_val("wr_data", obs_data[i], exp_data[i]);
      end
    end
  endtask

  initial begin
    reset = 1'b1; start_r = 1'b0; mode = 1'b0; cur = 0;
    s_hready = 1'b1; s_hresp = 1'b0; s_hrdata = '0;
    dphase = 1'b0; n_reads = 0; n_xfers = 0;
    rd_waits = 0; wr_waits = 0; stall_addr = 1'b0; err_read = 0;
    repeat (3) @(posedge clk);
    #1;
    for (int d = 0; d < 3; d++) begin
      cur = d;
      #1;
      check_all_zero("reset");
    end
    cur = 0;
    @(negedge clk); #4;
    reset = 1'b0;

    run_job(0, 1'b0, 0, 0, 1'b0, 0, 1'b0, 0, 0);
    run_job(0, 1'b1, 0, 0, 1'b0, 0, 1'b0, 0, 0);
    run_job(1, 1'b1, 0, 0, 1'b0, 0, 1'b0, 1, 0);
    run_job(0, 1'($urandom_range(0, 1)), 3, 0, 1'b0, 0, 1'b0, 2, 0);
    run_job(2, 1'b0, 0, 0, 1'b0, 0, 1'b1, 2, 0);
    run_job(2, 1'b1, 1, 2, 1'b1, 0, 1'b0, 2, 0);
    for (int i = 0; i < 4; i++)
      run_job(1, 1'($urandom_range(0, 1)), int'($urandom_range(0, 2)),
              int'($urandom_range(0, 2)), 1'(i % 2), 0, 1'b0, 2, 0);
    for (int i = 0; i < 2; i++)
      run_job(2, 1'($urandom_range(0, 1)), int'($urandom_range(0, 3)),
              int'($urandom_range(0, 3)), 1'b1, 0, 1'b0, 2, 0);

    // Slave ERROR on the third read
    run_job(0, 1'b0, 0, 0, 1'b0, 3, 1'b0, 2, 0);
    check_val("err_error", 32'(m_error), 32'd1);
    check_val("err_busy", 32'(m_busy), 32'd0);
    check_val("err_finish", 32'(m_finish), 32'd0);
    check_val("err_writes", 32'(obs_addr.size()), 32'd0);
    check_val("err_reads", 32'(n_reads), 32'd3);
    start_r = 1'b1;
    repeat (20) @(negedge clk);
    #4;
    start_r = 1'b0;
    check_val("err_hold", 32'(m_error), 32'd1);
    check_val("err_no_xfer", 32'(n_xfers), 32'd3);
    check_val("err_hold_busy", 32'(m_busy), 32'd0);
    reset = 1'b1;
    @(posedge clk); #1;
    check_all_zero("err_reset");
    @(negedge clk); #4;
    reset = 1'b0;

    // Reset during a write data phase, then a clean rerun
    run_job(1, 1'b0, 0, 3, 1'b0, 0, 1'b0, 2, 2);
    run_job(1, 1'b0, 0, 3, 1'b0, 0, 1'b0, 2, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #900000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
